// File: rtl/wave_generator_if.sv
// Bus bundle for wave_generator: control inputs from the consumer side, waveform outputs back.
// The master modport drives ena/mode/step/limit; the slave (generator) returns out/dir/period.
interface wave_generator_if #(
  parameter int unsigned N = 8
);
  logic         ena;
  logic [1:0]   mode;
  logic [N-1:0] step;
  logic [N-1:0] limit;
  logic [N-1:0] out;
  logic         dir;
  logic         period;

  modport master (
    output ena, mode, step, limit,
    input  out, dir, period
  );

  modport slave (
    input  ena, mode, step, limit,
    output out, dir, period
  );
endinterface

// File: rtl/wave_generator.sv
// Multi-mode waveform generator (triangle, saw up, saw down, square) with runtime step/limit.
// Optional registered period-start strobe enabled by `WAVEGEN_PERIOD_PULSE_EN; otherwise period ties to 0.
module wave_generator #(
  parameter int unsigned N = 8
) (
  input  logic             clk,
  input  logic             rst,
  wave_generator_if.slave  bus
);

  localparam int unsigned W = N + 1;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    M_TRI    = 2'b00,
    M_SAW_UP = 2'b01,
    M_SAW_DN = 2'b10,
    M_SQUARE = 2'b11
  } mode_e;

  logic [N-1:0] r_acc;
  dir_e         r_dir;
  mode_e        r_mode;

  // Widened operands so sums and comparisons never wrap.
  logic [W-1:0] w_acc_x;
  logic [W-1:0] w_step_x;
  logic [W-1:0] w_lim_x;
  logic [W-1:0] w_sum;
  logic [N-1:0] w_diff;
  logic [N-1:0] w_diff_clip;
  logic [N-1:0] w_sum_clip;
  logic         w_mode_chg;
  logic         w_over;
  logic         w_sum_ge;
  logic         w_dn_floor;
  logic         w_at_zero;

  assign w_acc_x     = W'(r_acc);
  assign w_step_x    = W'(bus.step);
  assign w_lim_x     = W'(bus.limit);
  assign w_sum       = w_acc_x + w_step_x;
  assign w_diff      = r_acc - bus.step;
  assign w_mode_chg  = (bus.mode != r_mode);
  assign w_over      = (w_acc_x > w_lim_x);
  assign w_sum_ge    = (w_sum >= w_lim_x);
  assign w_dn_floor  = (w_acc_x <= w_step_x);
  assign w_at_zero   = (r_acc == '0);
  assign w_sum_clip  = w_sum_ge ? bus.limit : w_sum[N-1:0];
  assign w_diff_clip = (W'(w_diff) > w_lim_x) ? bus.limit : w_diff;

  // Direction/accumulator state machine; advances only on enabled cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_dir  <= UP;
      r_mode <= M_TRI;
    end else if (bus.ena) begin
      if (w_mode_chg) begin
        r_mode <= mode_e'(bus.mode);
        r_acc  <= '0;
        r_dir  <= (mode_e'(bus.mode) == M_SAW_DN) ? DOWN : UP;
      end else begin
        unique case (r_mode)
          M_TRI, M_SQUARE: begin
            if (w_over || (r_dir == UP && w_sum_ge)) begin
              r_acc <= bus.limit;
              r_dir <= DOWN;
            end else if (r_dir == UP) begin
              r_acc <= w_sum[N-1:0];
            end else if (w_dn_floor) begin
              r_acc <= '0;
              r_dir <= UP;
            end else begin
              r_acc <= w_diff;
            end
          end
          M_SAW_UP: begin
            if (w_acc_x >= w_lim_x) r_acc <= '0;
            else                    r_acc <= w_sum_clip;
          end
          M_SAW_DN: begin
            if (w_at_zero)       r_acc <= bus.limit;
            else if (w_dn_floor) r_acc <= '0;
            else                 r_acc <= w_diff_clip;
          end
        endcase
      end
    end
  end

  // Square shows the full peak while ramping up and zero while ramping down.
  assign bus.out = (r_mode == M_SQUARE) ? ((r_dir == UP) ? bus.limit : '0) : r_acc;
  assign bus.dir = r_dir;

`ifdef WAVEGEN_PERIOD_PULSE_EN
  logic r_period;
  logic w_wrap;

  // Start of a new period: DOWN->UP turn, saw-up wrap, or saw-down reload.
  always_comb begin
    w_wrap = 1'b0;
    unique case (r_mode)
      M_TRI, M_SQUARE: w_wrap = (r_dir == DOWN) && !w_over && w_dn_floor;
      M_SAW_UP:        w_wrap = (w_acc_x >= w_lim_x);
      M_SAW_DN:        w_wrap = w_at_zero;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_period <= 1'b0;
    else     r_period <= bus.ena && !w_mode_chg && w_wrap;
  end

  assign bus.period = r_period;
`else
  assign bus.period = 1'b0;
`endif

endmodule

// File: tb/tb_wave_generator.sv
// Scoreboard bench for wave_generator: each driven cycle pushes its expected out/dir/period,
// which is popped and compared once the clock edge has produced the DUT response.
module tb_wave_generator;

  localparam int unsigned N = 8;

`ifdef WAVEGEN_PERIOD_PULSE_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  typedef struct {
    string        tag;
    logic [N-1:0] out;
    logic         dir;
    logic         period;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  wave_generator_if #(.N(N)) bus ();

  wave_generator #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, push the expected response, then pop and compare after the edge.
  task automatic cyc(input string tag, input bit r, input bit e, input logic [1:0] m,
                     input int s, input int l, input int eo, input bit ed, input bit ep);
    exp_t x;
    exp_t y;
    x.tag    = tag;
    x.out    = N'(eo);
    x.dir    = ed;
    x.period = PE & ep;
    sb.push_back(x);
    rst       = r;
    bus.ena   = e;
    bus.mode  = m;
    bus.step  = N'(s);
    bus.limit = N'(l);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got 0 expected 1 entry", tag);
    end else begin
      y = sb.pop_front();
      check_eq({y.tag, ".out"},    32'(bus.out),    32'(y.out));
      check_eq({y.tag, ".dir"},    32'(bus.dir),    32'(y.dir));
      check_eq({y.tag, ".period"}, 32'(bus.period), 32'(y.period));
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.ena   = 1'b1;
    bus.mode  = 2'b00;
    bus.step  = '0;
    bus.limit = '0;

    // Reset with ena high and a foreign mode request: reset wins.
    cyc("rst0", 1, 1, 2'b01, 3, 10, 0, 1, 0);
    cyc("rst1", 1, 1, 2'b01, 3, 10, 0, 1, 0);

    // Triangle, limit 10, step 3.
    cyc("tri3",  0, 1, 2'b00, 3, 10,  3, 1, 0);
    cyc("tri6",  0, 1, 2'b00, 3, 10,  6, 1, 0);
    cyc("tri9",  0, 1, 2'b00, 3, 10,  9, 1, 0);
    cyc("tri10", 0, 1, 2'b00, 3, 10, 10, 0, 0);
    cyc("tri7",  0, 1, 2'b00, 3, 10,  7, 0, 0);
    cyc("tri4",  0, 1, 2'b00, 3, 10,  4, 0, 0);
    cyc("tri1",  0, 1, 2'b00, 3, 10,  1, 0, 0);
    cyc("tri0",  0, 1, 2'b00, 3, 10,  0, 1, 1);
    cyc("tri3b", 0, 1, 2'b00, 3, 10,  3, 1, 0);
    cyc("tri6b", 0, 1, 2'b00, 3, 10,  6, 1, 0);
    // Enable low: state frozen, mode request ignored.
    for (int i = 0; i < 3; i++) cyc($sformatf("tri_hold%0d", i), 0, 0, 2'b10, 3, 10, 6, 1, 0);
    cyc("tri9b", 0, 1, 2'b00, 3, 10, 9, 1, 0);

    // Saw up, limit 5, step 2 (first cycle is the mode change).
    cyc("su_chg", 0, 1, 2'b01, 2, 5, 0, 1, 0);
    cyc("su2",    0, 1, 2'b01, 2, 5, 2, 1, 0);
    cyc("su4",    0, 1, 2'b01, 2, 5, 4, 1, 0);
    cyc("su5",    0, 1, 2'b01, 2, 5, 5, 1, 0);
    cyc("su0",    0, 1, 2'b01, 2, 5, 0, 1, 1);
    cyc("su2b",   0, 1, 2'b01, 2, 5, 2, 1, 0);

    // Saw down, limit 5, step 2.
    cyc("sd_chg", 0, 1, 2'b10, 2, 5, 0, 0, 0);
    cyc("sd5",    0, 1, 2'b10, 2, 5, 5, 0, 1);
    cyc("sd3",    0, 1, 2'b10, 2, 5, 3, 0, 0);
    cyc("sd1",    0, 1, 2'b10, 2, 5, 1, 0, 0);
    cyc("sd0",    0, 1, 2'b10, 2, 5, 0, 0, 0);
    cyc("sd5b",   0, 1, 2'b10, 2, 5, 5, 0, 1);
    cyc("sd3b",   0, 1, 2'b10, 2, 5, 3, 0, 0);

    // Square, limit 4, step 1.
    cyc("sq_chg", 0, 1, 2'b11, 1, 4, 4, 1, 0);
    for (int i = 0; i < 3; i++) cyc($sformatf("sq_hi%0d", i), 0, 1, 2'b11, 1, 4, 4, 1, 0);
    for (int i = 0; i < 4; i++) cyc($sformatf("sq_lo%0d", i), 0, 1, 2'b11, 1, 4, 0, 0, 0);
    cyc("sq_turn", 0, 1, 2'b11, 1, 4, 4, 1, 1);
    for (int i = 0; i < 3; i++) cyc($sformatf("sq_hold%0d", i), 0, 0, 2'b00, 1, 4, 4, 1, 0);
    cyc("sq_resume", 0, 1, 2'b11, 1, 4, 4, 1, 0);

    // step 0 at acc 0 in triangle: holds at 0.
    cyc("z_chg", 0, 1, 2'b00, 0, 10, 0, 1, 0);
    cyc("z0",    0, 1, 2'b00, 0, 10, 0, 1, 0);
    cyc("z1",    0, 1, 2'b00, 0, 10, 0, 1, 0);

    // limit 0: out stays 0, dir toggles.
    cyc("l0_a", 0, 1, 2'b00, 3, 0, 0, 0, 0);
    cyc("l0_b", 0, 1, 2'b00, 3, 0, 0, 1, 1);
    cyc("l0_c", 0, 1, 2'b00, 3, 0, 0, 0, 0);
    cyc("l0_d", 0, 1, 2'b00, 3, 0, 0, 1, 1);

    // Ramp to 120 under limit 200, then drop limit to 50.
    cyc("lim40",  0, 1, 2'b00, 40, 200,  40, 1, 0);
    cyc("lim80",  0, 1, 2'b00, 40, 200,  80, 1, 0);
    cyc("lim120", 0, 1, 2'b00, 40, 200, 120, 1, 0);
    cyc("lim50",  0, 1, 2'b00, 40,  50,  50, 0, 0);

    // Mid-ramp reset, then wide-step triangle near the top of the range.
    cyc("rst_mid", 1, 1, 2'b11, 200, 255, 0, 1, 0);
    cyc("w200", 0, 1, 2'b00, 200, 255, 200, 1, 0);
    cyc("w255", 0, 1, 2'b00, 200, 255, 255, 0, 0);
    cyc("w55",  0, 1, 2'b00, 200, 255,  55, 0, 0);
    cyc("w0",   0, 1, 2'b00, 200, 255,   0, 1, 1);

    check_eq("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
